palindrome_generator: RTL and testbench



---
 rtl/palindrome_pkg.sv | 24 ++
 rtl/palindrome_lifo.sv | 53 +++++
 rtl/palindrome_generator.sv | 128 ++++++++++++
 tb/tb_palindrome_generator.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/palindrome_pkg.sv
// rtl/palindrome_pkg.sv - shared types and helpers for the palindrome generator
package palindrome_pkg;

    typedef enum logic {
        FILL   = 1'b0,
        MIRROR = 1'b1
    } state_t;

    localparam int MAX_WIDTH = 64;

    // Width-generic: callers widen to MAX_WIDTH and truncate the result back.
    function automatic logic [MAX_WIDTH-1:0] bit_reverse(input logic [MAX_WIDTH-1:0] value,
                                                         input int width);
        logic [MAX_WIDTH-1:0] result;
        result = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) begin
                result[i] = value[width-1-i];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/palindrome_lifo.sv
// rtl/palindrome_lifo.sv - word stack holding the forward pass for mirroring
module palindrome_lifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW + 1)'(DEPTH));
    assign count = count_q;
    assign rdata = mem[AW'(count_q - ONE)];

    always_comb begin
        count_d = count_q;
        if (push && !full) begin
            count_d = count_q + ONE;
        end else if (pop && !empty) begin
            count_d = count_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Storage is not reset; only the pointer decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[count_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/palindrome_generator.sv
// rtl/palindrome_generator.sv - forwards a frame, then replays it reversed and bit-mirrored
module palindrome_generator
    import palindrome_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             truncated
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             trunc_q, trunc_d;

    logic             reg_free;
    logic             accept;
    logic             hits_depth;
    logic             push, pop;
    logic             lifo_empty, lifo_full;
    logic [CW-1:0]    lifo_count;
    logic [WIDTH-1:0] lifo_rdata;
    logic [WIDTH-1:0] mirror_word;

    palindrome_lifo #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_lifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .wdata(in_data),
        .rdata(lifo_rdata),
        .empty(lifo_empty),
        .full (lifo_full),
        .count(lifo_count)
    );

    assign reg_free    = !out_valid_q || out_ready;
    assign accept      = in_valid && in_ready;
    assign hits_depth  = (lifo_count == CW'(DEPTH - 1));
    assign mirror_word = WIDTH'(bit_reverse(MAX_WIDTH'(lifo_rdata), WIDTH));

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign truncated = trunc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            trunc_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            trunc_q     <= trunc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: begin
                if (accept && (in_last || hits_depth)) begin
                    state_d = MIRROR;
                end
            end
            MIRROR: begin
                // Stack drained and the out_last word is leaving the register.
                if (lifo_empty && reg_free) begin
                    state_d = FILL;
                end
            end
        endcase
    end

    always_comb begin
        in_ready    = !rst && (state_q == FILL) && reg_free && !lifo_full;
        push        = 1'b0;
        pop         = 1'b0;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        trunc_d     = 1'b0;
        if (reg_free) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            FILL: begin
                if (accept) begin
                    push        = 1'b1;
                    out_valid_d = 1'b1;
                    out_data_d  = in_data;
                    out_last_d  = 1'b0;
                    trunc_d     = !in_last && hits_depth;
                end
            end
            MIRROR: begin
                if (reg_free && !lifo_empty) begin
                    pop         = 1'b1;
                    out_valid_d = 1'b1;
                    out_data_d  = mirror_word;
                    out_last_d  = (lifo_count == CW'(1));
                end
            end
        endcase
    end

endmodule

// File: tb/tb_palindrome_generator.sv
// tb/tb_palindrome_generator.sv - self-checking bench against a queue-based palindrome model
module tb_palindrome_generator;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             truncated;

    palindrome_generator #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_last (out_last),
        .truncated(truncated)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       l;
        bit         m;
    } ent_t;

    ent_t       exp_q[$];
    ent_t       log_q[$];
    logic [7:0] frame_q[$];
    logic [7:0] words[$];
    logic [8:0] exp_log[$];

    int         checks = 0;
    int         errors = 0;
    int         trunc_seen = 0;
    int         trunc_expected = 0;
    bit         exp_trunc = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        r = {<<{x}};
        return r;
    endfunction

    function automatic bit has_mirror();
        foreach (exp_q[i]) if (exp_q[i].m) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic pick_ready(input int mode);
        if (mode == 0) return 1'b1;
        return ($urandom_range(0, 2) != 0);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Frame semantics: forward copy now; at frame end append reversed, bit-mirrored copy.
    task automatic model_accept(input logic [7:0] d, input logic l);
        exp_q.push_back('{d, 1'b0, 1'b0});
        frame_q.push_back(d);
        if (l || frame_q.size() == DEPTH) begin
            if (!l) begin
                exp_trunc = 1'b1;
                trunc_expected++;
            end
            for (int i = frame_q.size() - 1; i >= 0; i--) begin
                exp_q.push_back('{rev8(frame_q[i]), (i == 0), 1'b1});
            end
            frame_q.delete();
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic l, input logic r,
                        output bit acc);
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        out_ready = r;
        #1;
        chk("truncated", truncated, exp_trunc);
        if (truncated) trunc_seen++;
        exp_trunc = 1'b0;
        chk("out_valid", out_valid, (exp_q.size() != 0));
        if (prev_stall) begin
            chk("hold_data", out_data, prev_data);
            chk("hold_last", out_last, prev_last);
        end
        chk("in_ready", in_ready, !has_mirror() && (!out_valid || out_ready));
        if (out_valid && out_ready && exp_q.size() != 0) begin
            chk("out_data", out_data, exp_q[0].d);
            chk("out_last", out_last, exp_q[0].l);
            log_q.push_back('{out_data, out_last, exp_q[0].m});
            exp_q.pop_front();
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        acc = v && in_ready;
        if (acc) model_accept(d, l);
    endtask

    task automatic run_frame(input bit lastflag, input int mode);
        int idx = 0;
        int guard = 0;
        bit acc;
        while (idx < words.size() && guard < 500) begin
            step(1'b1, words[idx], lastflag && (idx == words.size() - 1), pick_ready(mode), acc);
            if (acc) idx++;
            guard++;
        end
        chk("frame_accepted", idx, words.size());
    endtask

    task automatic drain(input int mode);
        int guard = 0;
        bit acc;
        while (exp_q.size() != 0 && guard < 300) begin
            step(1'b0, 8'h00, 1'b0, pick_ready(mode), acc);
            guard++;
        end
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic check_log(input string tag);
        chk({tag, "_len"}, log_q.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < log_q.size(); i++) begin
            chk(tag, {log_q[i].l, log_q[i].d}, exp_log[i]);
        end
        log_q.delete();
    endtask

    task automatic reset_dut();
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_truncated", truncated, 1'b0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);
        exp_q.delete();
        frame_q.delete();
        exp_trunc  = 1'b0;
        prev_stall = 1'b0;
    endtask

    initial begin
        bit acc;
        int guard;
        int len;

        reset_dut();

        words = '{8'h01};
        run_frame(1'b1, 0);
        drain(0);
        exp_log = '{9'h001, 9'h180};
        check_log("one_word");

        words = '{8'h12, 8'h34, 8'h56};
        run_frame(1'b1, 0);
        drain(0);
        exp_log = '{9'h012, 9'h034, 9'h056, 9'h06A, 9'h02C, 9'h148};
        check_log("three_word");

        run_frame(1'b1, 1);
        drain(1);
        check_log("backpressure");

        words = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        run_frame(1'b0, 0);
        words = '{8'h3C};
        run_frame(1'b1, 0);
        drain(0);
        exp_log = '{9'h0A1, 9'h0A2, 9'h0A3, 9'h0A4, 9'h025, 9'h0C5, 9'h045, 9'h185,
                    9'h0A5, 9'h03C, 9'h03C, 9'h1A5};
        check_log("truncation");
        chk("trunc_pulses", trunc_seen, 1);

        words = '{8'h12, 8'h34, 8'h56};
        run_frame(1'b1, 0);
        guard = 0;
        while (log_q.size() < 5 && guard < 50) begin
            step(1'b0, 8'h00, 1'b0, 1'b1, acc);
            guard++;
        end
        chk("pre_reset_words", log_q.size(), 5);
        log_q.delete();
        reset_dut();
        words = '{8'hFF};
        run_frame(1'b1, 0);
        drain(0);
        exp_log = '{9'h0FF, 9'h1FF};
        check_log("after_reset");

        words = '{8'h0F};
        run_frame(1'b1, 0);
        words = '{8'hF0};
        run_frame(1'b1, 0);
        drain(0);
        exp_log = '{9'h00F, 9'h1F0, 9'h0F0, 9'h10F};
        check_log("back_to_back");

        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 6);
            words.delete();
            for (int k = 0; k < len; k++) words.push_back(8'($urandom));
            run_frame(1'b1, 1);
        end
        drain(1);
        log_q.delete();
        step(1'b0, 8'h00, 1'b0, 1'b1, acc);
        chk("trunc_total", trunc_seen, trunc_expected);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
